// File: rtl/jsilicon_pkg.sv
// jsilicon_pkg
//   Shared definitions for the parametrised jsilicon compute core:
//   opcode constants, control-state encodings and a small opcode helper.
//   No ports; imported by jsilicon_core_p and jsilicon_uart_tx.
package jsilicon_pkg;

  // Opcode encodings (3-bit opcode field)
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_CMP = 3'd7;

  // Control states of the core sequencer
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_TX   = 2'd2
  } state_t;

  // UART frame length in bit times: start + 8 data + stop
  localparam int FRAME_BITS = 10;

  // Multiply and divide run one bit per cycle; everything else is one step.
  // A divide by zero is short-circuited by the core and is not iterative.
  function automatic logic op_is_iterative(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/jsilicon_uart_tx.sv
// jsilicon_uart_tx
//   8N1 serialiser. A byte presented with valid while ready is high is
//   framed as start(0), 8 data bits LSB first, stop(1); each bit lasts
//   CLK_DIV clocks. ready is also high during the final clock of a stop
//   bit so that a waiting byte starts with no idle gap (back-to-back frames).
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   synchronous active-high reset (line returns to idle)
//   ena        in   global enable; 0 freezes every register
//   data[7:0]  in   byte to send
//   valid      in   byte available
//   ready      out  byte will be accepted at the next enabled edge
//   uart_busy  out  a frame is in progress
//   tx         out  serial line, idles high
module jsilicon_uart_tx
  import jsilicon_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ena,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       uart_busy,
  output logic       tx
);

  localparam int BAUD_W = $clog2(CLK_DIV);

  logic [BAUD_W-1:0] baud_reg;
  logic [3:0]        bit_reg;
  logic [8:0]        shift_reg;   // remaining data bits plus the stop bit
  logic              busy_reg;
  logic              tx_reg;

  logic bit_end;
  logic frame_end;

  assign bit_end   = (baud_reg == BAUD_W'(CLK_DIV - 1));
  assign frame_end = busy_reg && bit_end && (bit_reg == 4'(FRAME_BITS - 1));
  assign ready     = !busy_reg || frame_end;
  assign uart_busy = busy_reg;
  assign tx        = tx_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '1;
      busy_reg  <= 1'b0;
      tx_reg    <= 1'b1;
    end else if (ena) begin
      if (valid && ready) begin
        // Start bit goes out immediately; data and stop bit wait in shift_reg
        shift_reg <= {1'b1, data};
        tx_reg    <= 1'b0;
        baud_reg  <= '0;
        bit_reg   <= '0;
        busy_reg  <= 1'b1;
      end else if (frame_end) begin
        busy_reg <= 1'b0;
        tx_reg   <= 1'b1;
        baud_reg <= '0;
        bit_reg  <= '0;
      end else if (busy_reg) begin
        if (bit_end) begin
          baud_reg  <= '0;
          bit_reg   <= bit_reg + 4'd1;
          tx_reg    <= shift_reg[0];
          shift_reg <= {1'b1, shift_reg[8:1]};
        end else begin
          baud_reg <= baud_reg + BAUD_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/jsilicon_core_p.sv
// jsilicon_core_p
//   Parametrised compute core. On an accepted start it latches two DATA_W
//   operands and an opcode, executes a single-step or bit-serial
//   (multiply/divide) operation, registers a 2*DATA_W result and, when
//   UART_EN=1, streams the result low byte first over an 8N1 UART before
//   pulsing done.
//   DATA_W must be a multiple of 4 in 4..16; CLK_DIV must be >= 2.
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   ena          in   global enable; 0 freezes all state, start ignored
//   start        in   request, accepted only in IDLE with ena=1
//   a, b         in   DATA_W operands, sampled on accept
//   opcode[2:0]  in   operation, sampled on accept
//   busy         out  high from the cycle after accept until done
//   done         out  one-cycle completion pulse
//   err          out  divide-by-zero flag, sticky until the next accept
//   result       out  registered 2*DATA_W result
//   uart_tx      out  serial line, idles high
//   uart_busy    out  high while a UART frame is in progress
module jsilicon_core_p
  import jsilicon_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 16,
  parameter int UART_EN = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ena,
  input  logic                start,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [2:0]          opcode,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [2*DATA_W-1:0] result,
  output logic                uart_tx,
  output logic                uart_busy
);

  localparam int RES_W  = 2 * DATA_W;
  localparam int NBYTES = RES_W / 8;
  localparam int CNT_W  = 5;

  state_t            state_reg;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic [2:0]        op_reg;
  // Working register: product accumulator for MUL, {remainder, quotient}
  // for DIV, and the staged value for single-step ops.
  logic [RES_W-1:0]  work_reg;
  logic [RES_W-1:0]  result_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              wb_reg;      // EXEC finished computing; next edge writes result
  logic              div0_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              err_reg;
  logic [2:0]        byte_idx_reg;

  // ---------------------------------------------------------------
  // Single-step ALU
  // ---------------------------------------------------------------
  logic [DATA_W:0]  sum_ext;
  logic [DATA_W:0]  diff_ext;
  logic [RES_W-1:0] single_res;

  assign sum_ext  = {1'b0, a_reg} + {1'b0, b_reg};
  // Top bit of the extended difference is exactly the borrow (a < b)
  assign diff_ext = {1'b0, a_reg} - {1'b0, b_reg};

  always_comb begin
    single_res = '0;
    case (op_reg)
      OP_ADD:  single_res[DATA_W:0]   = sum_ext;
      OP_SUB:  single_res[DATA_W:0]   = diff_ext;
      OP_AND:  single_res[DATA_W-1:0] = a_reg & b_reg;
      OP_OR:   single_res[DATA_W-1:0] = a_reg | b_reg;
      OP_XOR:  single_res[DATA_W-1:0] = a_reg ^ b_reg;
      OP_CMP:  single_res[2:0]        = {a_reg > b_reg, a_reg == b_reg, a_reg < b_reg};
      default: single_res             = '0;
    endcase
  end

  // ---------------------------------------------------------------
  // Shift-add multiply step: work = {accumulator, remaining multiplier}
  // ---------------------------------------------------------------
  logic [DATA_W:0]  mul_sum;
  logic [RES_W-1:0] mul_next;

  assign mul_sum  = {1'b0, work_reg[RES_W-1:DATA_W]} + (work_reg[0] ? {1'b0, a_reg} : '0);
  assign mul_next = {mul_sum, work_reg[DATA_W-1:1]};

  // ---------------------------------------------------------------
  // Restoring divide step: work = {remainder, dividend/quotient}
  // ---------------------------------------------------------------
  logic [DATA_W:0]   div_shift;
  logic              div_ge;
  logic [DATA_W-1:0] div_rem;
  logic [RES_W-1:0]  div_next;

  assign div_shift = {work_reg[RES_W-1:DATA_W], work_reg[DATA_W-1]};
  assign div_ge    = (div_shift >= {1'b0, b_reg});
  // After a successful subtract the remainder is below b, so it fits DATA_W
  assign div_rem   = DATA_W'(div_shift - {1'b0, b_reg});
  assign div_next  = div_ge ? {div_rem, work_reg[DATA_W-2:0], 1'b1}
                            : {div_shift[DATA_W-1:0], work_reg[DATA_W-2:0], 1'b0};

  logic iter_op;
  logic last_iter;

  assign iter_op   = op_is_iterative(op_reg) && !(op_reg == OP_DIV && b_reg == '0);
  assign last_iter = (cnt_reg == CNT_W'(DATA_W - 1));

  // ---------------------------------------------------------------
  // UART byte sequencing
  // ---------------------------------------------------------------
  logic       tx_valid;
  logic       tx_ready;
  logic       ser_busy;
  logic       ser_tx;
  logic [7:0] tx_byte;

  assign tx_valid = (state_reg == ST_TX) && (byte_idx_reg < 3'(NBYTES));
  assign tx_byte  = 8'(result_reg >> {byte_idx_reg, 3'b000});

  jsilicon_uart_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_uart (
    .clock     (clock),
    .reset     (reset),
    .ena       (ena),
    .data      (tx_byte),
    .valid     (tx_valid),
    .ready     (tx_ready),
    .uart_busy (ser_busy),
    .tx        (ser_tx)
  );

  // ---------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      a_reg        <= '0;
      b_reg        <= '0;
      op_reg       <= OP_ADD;
      work_reg     <= '0;
      result_reg   <= '0;
      cnt_reg      <= '0;
      wb_reg       <= 1'b0;
      div0_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      byte_idx_reg <= '0;
    end else if (ena) begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            a_reg    <= a;
            b_reg    <= b;
            op_reg   <= opcode;
            err_reg  <= 1'b0;
            div0_reg <= 1'b0;
            busy_reg <= 1'b1;
            cnt_reg  <= '0;
            wb_reg   <= 1'b0;
            // Seed the bit-serial engines: multiplier or dividend in the low half
            work_reg  <= (opcode == OP_MUL) ? {{DATA_W{1'b0}}, b} : {{DATA_W{1'b0}}, a};
            state_reg <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          if (!wb_reg) begin
            if (iter_op) begin
              work_reg <= (op_reg == OP_MUL) ? mul_next : div_next;
              cnt_reg  <= cnt_reg + CNT_W'(1);
              if (last_iter) wb_reg <= 1'b1;
            end else if (op_reg == OP_DIV) begin
              // Divide by zero: quotient saturates, remainder is the dividend
              work_reg <= {a_reg, {DATA_W{1'b1}}};
              div0_reg <= 1'b1;
              wb_reg   <= 1'b1;
            end else begin
              work_reg <= single_res;
              wb_reg   <= 1'b1;
            end
          end else begin
            result_reg <= work_reg;
            err_reg    <= div0_reg;
            if (UART_EN != 0) begin
              byte_idx_reg <= '0;
              state_reg    <= ST_TX;
            end else begin
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= ST_IDLE;
            end
          end
        end

        ST_TX: begin
          if (tx_valid && tx_ready) byte_idx_reg <= byte_idx_reg + 3'd1;
          // ready while busy marks the closing clock of the last stop bit
          if ((byte_idx_reg == 3'(NBYTES)) && tx_ready && ser_busy) begin
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign result    = result_reg;
  assign uart_tx   = ser_tx;
  assign uart_busy = ser_busy;

endmodule

// File: tb/tb_jsilicon_core_p.sv
// tb_jsilicon_core_p
//   Self-checking bench for jsilicon_core_p (DATA_W=8, CLK_DIV=4).
//   dut0 runs with UART_EN=0, dut1 with UART_EN=1. Expected results come
//   from a plain-arithmetic reference model; latencies from the timing rules.
module tb_jsilicon_core_p;

  localparam int DW = 8;
  localparam int CD = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        ena;
  logic        start0, start1;
  logic [7:0]  a, b;
  logic [2:0]  opcode;

  logic        busy0, done0, err0, uart_tx0, uart_busy0;
  logic [15:0] result0;
  logic        busy1, done1, err1, uart_tx1, uart_busy1;
  logic [15:0] result1;

  int check_cnt = 0;
  int pass_cnt  = 0;

  always #5 clock = ~clock;

  jsilicon_core_p #(.DATA_W(DW), .CLK_DIV(CD), .UART_EN(0)) dut0 (
    .clock(clock), .reset(reset), .ena(ena), .start(start0),
    .a(a), .b(b), .opcode(opcode),
    .busy(busy0), .done(done0), .err(err0), .result(result0),
    .uart_tx(uart_tx0), .uart_busy(uart_busy0)
  );

  jsilicon_core_p #(.DATA_W(DW), .CLK_DIV(CD), .UART_EN(1)) dut1 (
    .clock(clock), .reset(reset), .ena(ena), .start(start1),
    .a(a), .b(b), .opcode(opcode),
    .busy(busy1), .done(done1), .err(err1), .result(result1),
    .uart_tx(uart_tx1), .uart_busy(uart_busy1)
  );

  // ---------------- reference model ----------------
  // Returns {err, result[15:0]}
  function automatic logic [16:0] model(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
    int unsigned xi = x;
    int unsigned yi = y;
    logic [15:0] r;
    logic        e;
    e = 1'b0;
    case (op)
      3'd0: r = 16'(xi + yi);
      3'd1: r = 16'((xi - yi) & 255) | ((xi < yi) ? 16'h0100 : 16'h0000);
      3'd2: r = 16'(xi * yi);
      3'd3: begin
        if (yi == 0) begin
          e = 1'b1;
          r = {x, 8'hFF};
        end else begin
          r = 16'(((xi % yi) << 8) | (xi / yi));
        end
      end
      3'd4: r = 16'(xi & yi);
      3'd5: r = 16'(xi | yi);
      3'd6: r = 16'(xi ^ yi);
      default: r = 16'((xi > yi) * 4 + (xi == yi) * 2 + (xi < yi) * 1);
    endcase
    return {e, r};
  endfunction

  // Edges from accept to done when no UART is involved
  function automatic int model_lat(input logic [2:0] op, input logic [7:0] y);
    if (op == 3'd2 || (op == 3'd3 && y != 0)) return 1 + DW;
    return 2;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one operation into dut0 and wait (bounded) for done.
  // lat = number of edges from the accept edge to the edge raising done.
  task automatic do_op0(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                        output int lat, output logic [15:0] res, output logic e);
    a = x; b = y; opcode = op; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    lat = 0;
    while (!done0 && lat < 100) begin
      tick();
      lat++;
    end
    res = result0;
    e   = err0;
    $display("op=%0d a=%02h b=%02h -> result=%04h err=%0b latency=%0d", op, x, y, res, e, lat);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; ena = 1'b1; start0 = 1'b0; start1 = 1'b0;
    a = '0; b = '0; opcode = '0;
    repeat (3) tick();
    check_cnt++;
    if ({busy0, done0, err0, result0, uart_tx0, uart_busy0} !== {3'b000, 16'h0000, 2'b10}) begin
      $display("FAIL reset_dut0 got busy=%b done=%b err=%b result=%h tx=%b ubusy=%b want 0 0 0 0000 1 0",
               busy0, done0, err0, result0, uart_tx0, uart_busy0);
    end else pass_cnt++;
    check_cnt++;
    if ({busy1, done1, err1, result1, uart_tx1, uart_busy1} !== {3'b000, 16'h0000, 2'b10}) begin
      $display("FAIL reset_dut1 got busy=%b done=%b err=%b result=%h tx=%b ubusy=%b want 0 0 0 0000 1 0",
               busy1, done1, err1, result1, uart_tx1, uart_busy1);
    end else pass_cnt++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_add();
    int lat; logic [15:0] res; logic e;
    do_op0(3'd0, 8'hF0, 8'h20, lat, res, e);
    check_cnt++;
    if (res !== 16'h0110) $display("FAIL add_result got %h want 0110", res); else pass_cnt++;
    check_cnt++;
    if (lat !== 2) $display("FAIL add_latency got %0d want 2", lat); else pass_cnt++;
    check_cnt++;
    if (e !== 1'b0 || busy0 !== 1'b0) $display("FAIL add_err_busy got err=%b busy=%b want 0 0", e, busy0); else pass_cnt++;
    tick();
    check_cnt++;
    if (done0 !== 1'b0) $display("FAIL add_done_pulse got done=%b want 0", done0); else pass_cnt++;
  endtask

  task automatic test_mul();
    int lat; logic [15:0] res; logic e;
    do_op0(3'd2, 8'h0F, 8'h0D, lat, res, e);
    check_cnt++;
    if (res !== 16'h00C3) $display("FAIL mul_result got %h want 00c3", res); else pass_cnt++;
    check_cnt++;
    if (lat !== 9) $display("FAIL mul_latency got %0d want 9", lat); else pass_cnt++;
  endtask

  task automatic test_div();
    int lat; logic [15:0] res; logic e;
    do_op0(3'd3, 8'd200, 8'd7, lat, res, e);
    check_cnt++;
    if (res !== 16'h041C || lat !== 9) $display("FAIL div_result got %h lat %0d want 041c lat 9", res, lat); else pass_cnt++;
    do_op0(3'd3, 8'hC8, 8'h00, lat, res, e);
    check_cnt++;
    if (res !== 16'hC8FF || lat !== 2) $display("FAIL div0_result got %h lat %0d want c8ff lat 2", res, lat); else pass_cnt++;
    check_cnt++;
    if (e !== 1'b1) $display("FAIL div0_err got %b want 1", e); else pass_cnt++;
    // err is sticky while idle and cleared by the next accept
    tick();
    a = 8'h01; b = 8'h02; opcode = 3'd0; start0 = 1'b1;
    check_cnt++;
    if (err0 !== 1'b1) $display("FAIL err_sticky got %b want 1", err0); else pass_cnt++;
    tick();
    start0 = 1'b0;
    check_cnt++;
    if (err0 !== 1'b0) $display("FAIL err_clear got %b want 0", err0); else pass_cnt++;
    repeat (3) tick();
  endtask

  task automatic test_random();
    int lat; logic [15:0] res; logic e;
    logic [2:0] op; logic [7:0] x, y; logic [16:0] exp_v;
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      x  = 8'($urandom);
      y  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      exp_v = model(op, x, y);
      do_op0(op, x, y, lat, res, e);
      check_cnt++;
      if (res !== exp_v[15:0]) $display("FAIL rand_result op=%0d a=%h b=%h got %h want %h", op, x, y, res, exp_v[15:0]);
      else pass_cnt++;
      check_cnt++;
      if (e !== exp_v[16]) $display("FAIL rand_err op=%0d got %b want %b", op, e, exp_v[16]); else pass_cnt++;
      check_cnt++;
      if (lat !== model_lat(op, y)) $display("FAIL rand_latency op=%0d got %0d want %0d", op, lat, model_lat(op, y));
      else pass_cnt++;
    end
  endtask

  task automatic test_uart();
    logic [16:0] exp_v;
    logic [19:0] bits;
    int bad;
    logic early_done;
    exp_v = model(3'd0, 8'h12, 8'h34);
    // Two frames: start, data LSB first, stop -- byte 0 then byte 1
    bits = {1'b1, exp_v[15:8], 1'b0, 1'b1, exp_v[7:0], 1'b0};
    a = 8'h12; b = 8'h34; opcode = 3'd0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick(); tick();
    check_cnt++;
    if (result1 !== exp_v[15:0] || uart_tx1 !== 1'b1)
      $display("FAIL uart_result got %h tx=%b want %h tx=1", result1, uart_tx1, exp_v[15:0]);
    else pass_cnt++;
    bad = 0; early_done = 1'b0;
    for (int j = 0; j < 20 * CD; j++) begin
      tick();
      check_cnt++;
      if (uart_tx1 !== bits[j / CD]) begin
        $display("FAIL uart_bit clk=%0d got %b want %b", j, uart_tx1, bits[j / CD]);
        bad++;
      end else pass_cnt++;
      if (done1) early_done = 1'b1;
    end
    check_cnt++;
    if (early_done !== 1'b0) $display("FAIL uart_early_done got 1 want 0"); else pass_cnt++;
    tick();
    check_cnt++;
    if ({done1, busy1, uart_tx1, uart_busy1} !== 4'b1010)
      $display("FAIL uart_done got done=%b busy=%b tx=%b ubusy=%b want 1 0 1 0", done1, busy1, uart_tx1, uart_busy1);
    else pass_cnt++;
    $display("uart frame a=12 b=34 result=%h bit_errors=%0d", result1, bad);
    tick();
  endtask

  task automatic test_reset_midframe();
    int n;
    a = 8'hAB; b = 8'hCD; opcode = 3'd2; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n = 0;
    while (!uart_busy1 && n < 100) begin tick(); n++; end
    repeat (15) tick();
    check_cnt++;
    if (uart_busy1 !== 1'b1) $display("FAIL midframe_active got ubusy=%b want 1", uart_busy1); else pass_cnt++;
    reset = 1'b1;
    tick();
    check_cnt++;
    if ({uart_tx1, busy1, uart_busy1, result1} !== {3'b100, 16'h0000})
      $display("FAIL midframe_reset got tx=%b busy=%b ubusy=%b result=%h want 1 0 0 0000", uart_tx1, busy1, uart_busy1, result1);
    else pass_cnt++;
    reset = 1'b0;
    tick();
    $display("reset mid-frame after %0d wait cycles", n);
  endtask

  task automatic test_ena();
    int lat;
    logic moved;
    a = 8'h0F; b = 8'h0D; opcode = 3'd2; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (3) tick();
    ena = 1'b0;
    moved = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done0 || !busy0) moved = 1'b1;
    end
    ena = 1'b1;
    lat = 13;
    while (!done0 && lat < 100) begin tick(); lat++; end
    $display("ena-gap MUL result=%h latency=%0d", result0, lat);
    check_cnt++;
    if (lat !== 19) $display("FAIL ena_latency got %0d want 19", lat); else pass_cnt++;
    check_cnt++;
    if (result0 !== 16'h00C3 || moved !== 1'b0) $display("FAIL ena_result got %h moved=%b want 00c3 0", result0, moved);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_start_busy();
    int lat;
    a = 8'h0F; b = 8'h0D; opcode = 3'd2; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick(); tick();
    a = 8'hFF; b = 8'hFF; opcode = 3'd0; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    lat = 3;
    while (!done0 && lat < 100) begin tick(); lat++; end
    $display("start-while-busy MUL result=%h latency=%0d", result0, lat);
    check_cnt++;
    if (result0 !== 16'h00C3 || lat !== 9) $display("FAIL busy_start_result got %h lat %0d want 00c3 lat 9", result0, lat);
    else pass_cnt++;
    repeat (3) tick();
    check_cnt++;
    if (busy0 !== 1'b0) $display("FAIL busy_start_queued got busy=%b want 0", busy0); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int n;
    a = 8'h01; b = 8'h02; opcode = 3'd0; start0 = 1'b1;
    tick();
    n = 0;
    while (!done0 && n < 100) begin tick(); n++; end
    tick();
    check_cnt++;
    if (busy0 !== 1'b1 || done0 !== 1'b0) $display("FAIL held_start_reaccept got busy=%b done=%b want 1 0", busy0, done0);
    else pass_cnt++;
    start0 = 1'b0;
    a = 8'h00;
    n = 0;
    while (!done0 && n < 100) begin tick(); n++; end
    check_cnt++;
    if (result0 !== 16'h0003) $display("FAIL held_start_result got %h want 0003", result0); else pass_cnt++;
    $display("back-to-back second result=%h", result0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_div();
    test_random();
    test_uart();
    test_reset_midframe();
    test_ena();
    test_start_busy();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
